// File: rtl/instmem_pkg.sv
// Shared definitions for the boot-time program loader: frame constants,
// loader FSM states and the checksum helper.
package instmem_pkg;

  localparam int         IMEM_DEPTH_LOG2 = 6;
  localparam int         IMEM_WORDS      = 64;
  localparam logic [7:0] MAGIC           = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/instmem_ram64.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives a loader reset.
module instmem_ram64 #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd
);

  logic [31:0] r_mem [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign rd = r_mem[ra];

endmodule

// File: rtl/instmem_loader_v4.sv
// Framed byte-stream program loader feeding the instruction RAM; holds the
// core in reset until a frame with a valid checksum has been written.
module instmem_loader_v4 #(
  parameter int         DEPTH_LOG2 = 6,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] a,
  output logic [31:0] inst,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic        core_clrn
);

  import instmem_pkg::*;

  localparam int         CW        = DEPTH_LOG2 + 1;
  localparam logic [8:0] MAX_WORDS = 9'd1 << DEPTH_LOG2;

  loader_state_e         r_state;
  loader_state_e         w_next_state;
  logic [CW-1:0]         r_count;
  logic [1:0]            r_byte_cnt;
  logic [DEPTH_LOG2-1:0] r_word_idx;
  logic [7:0]            r_sum;
  logic [23:0]           r_asm;
  logic                  r_rx_ready;
  logic                  r_load_busy;
  logic                  r_load_done;
  logic                  r_load_err;
  logic                  r_core_clrn;

  logic                  w_xfer;
  logic                  w_is_magic;
  logic                  w_count_ok;
  logic                  w_last_word;
  logic                  w_we;
  logic [31:0]           w_wd;
  logic [7:0]            w_csum_total;
  logic                  w_unused_a;

  assign w_xfer       = rx_valid & r_rx_ready;
  assign w_is_magic   = (rx_data == MAGIC);
  assign w_count_ok   = (rx_data != 8'd0) && ({1'b0, rx_data} <= MAX_WORDS);
  assign w_last_word  = ({1'b0, r_word_idx} == (r_count - {{(CW-1){1'b0}}, 1'b1}));
  assign w_csum_total = csum_add(r_sum, rx_data);
  assign w_wd         = {rx_data, r_asm};
  assign w_unused_a   = ^{a[31:DEPTH_LOG2+2], a[1:0]};

  // Next-state and RAM write-enable decode
  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_is_magic) begin
          w_next_state = ST_COUNT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (w_xfer) begin
          w_next_state = w_count_ok ? ST_DATA : ST_ERROR;
        end else begin
          w_next_state = ST_COUNT;
        end
      end
      ST_DATA: begin
        if (w_xfer && (r_byte_cnt == 2'd3)) begin
          w_we         = 1'b1;
          w_next_state = w_last_word ? ST_CSUM : ST_DATA;
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (w_xfer) begin
          w_next_state = (w_csum_total == 8'd0) ? ST_DONE : ST_ERROR;
        end else begin
          w_next_state = ST_CSUM;
        end
      end
      ST_DONE: begin
        w_next_state = ST_DONE;
      end
      ST_ERROR: begin
        if (w_xfer && w_is_magic) begin
          w_next_state = ST_COUNT;
        end else begin
          w_next_state = ST_ERROR;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register and frame datapath (count, byte assembler, checksum)
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state    <= ST_IDLE;
      r_count    <= {CW{1'b0}};
      r_byte_cnt <= 2'd0;
      r_word_idx <= {DEPTH_LOG2{1'b0}};
      r_sum      <= 8'd0;
      r_asm      <= 24'd0;
    end else begin
      r_state <= w_next_state;
      if (w_xfer) begin
        case (r_state)
          ST_IDLE, ST_ERROR: begin
            if (w_is_magic) begin
              r_sum      <= 8'd0;
              r_byte_cnt <= 2'd0;
              r_word_idx <= {DEPTH_LOG2{1'b0}};
            end
          end
          ST_COUNT: begin
            r_count <= rx_data[CW-1:0];
          end
          ST_DATA: begin
            // Bytes arrive LSB first, so shift new bytes in from the top
            r_asm      <= {rx_data, r_asm[23:8]};
            r_sum      <= w_csum_total;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_word_idx <= r_word_idx + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            r_sum <= r_sum;
          end
        endcase
      end
    end
  end

  // Status outputs registered from the upcoming state
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_rx_ready  <= 1'b1;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_core_clrn <= 1'b0;
    end else begin
      r_rx_ready  <= (w_next_state != ST_DONE);
      r_load_busy <= (w_next_state == ST_COUNT) || (w_next_state == ST_DATA) ||
                     (w_next_state == ST_CSUM);
      r_load_done <= (w_next_state == ST_DONE);
      r_load_err  <= (w_next_state == ST_ERROR);
      r_core_clrn <= (w_next_state == ST_DONE);
    end
  end

  assign rx_ready  = r_rx_ready;
  assign load_busy = r_load_busy;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign core_clrn = r_core_clrn;

  instmem_ram64 #(
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk (clk),
    .we  (w_we),
    .wa  (r_word_idx),
    .wd  (w_wd),
    .ra  (a[DEPTH_LOG2+1:2]),
    .rd  (inst)
  );

endmodule

// File: doc/instmem_loader_v4.md
# instmem_loader_v4

Boot-time program loader and writable instruction memory for the RV32IM_V4 core. It accepts a framed byte stream (magic, word count, little-endian instruction words, checksum), writes the words into a 64×32 instruction RAM, and holds the core in reset until a frame has loaded and its checksum verifies. Its read port has the same shape as the core's instruction-memory port (`a` in, `inst` out, word index `a[7:2]`), so it drops in where the fixed program ROM sits today.

## Interface
- `DEPTH_LOG2`, 6: log2 of RAM depth in words; max word count = 2^DEPTH_LOG2.
- `MAGIC`, 8'hA5: frame start byte.

Ports:
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `clrn`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  byte from the serial front end.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs on an edge where `rx_valid & rx_ready`.
- `a`  in  32  fetch byte address; only `a[7:2]` is used.
- `inst`  out  32  equals `mem[a[7:2]]`; combinational read.
- `load_busy`  out  1  a frame is in progress (COUNT, DATA or CSUM).
- `load_done`  out  1  a frame loaded with a valid checksum; sticky.
- `load_err`  out  1  the last frame was rejected.
- `core_clrn`  out  1  active-low reset to the core; low until `load_done`.

## Operation
- States: IDLE, COUNT, DATA, CSUM, DONE, ERROR.
- **IDLE**
  - Byte == MAGIC → COUNT; clear the checksum accumulator, byte counter and word index.
  - Any other byte is accepted and discarded.
- **COUNT**
  - Byte N with 1 ≤ N ≤ 64 → latch N, go to DATA.
  - N == 0 or N > 64 → ERROR.
- **DATA**
  - Bytes assemble LSB first; the 2-bit byte counter wraps 3→0.
  - The 4th byte of a word writes `{b3,b2,b1,b0}` to `mem[word_idx]` on the same edge, then `word_idx` increments.
  - After word N−1 is written → CSUM.
  - Each data byte is added into an 8-bit sum, modulo 256.
- **CSUM**
  - Accept one byte. If `(sum + byte) mod 256 == 0` → DONE, else → ERROR.
  - Words already written stay in RAM in both cases.
- **DONE**
  - Terminal until `clrn`.
  - `rx_ready` = 0; `load_done` = 1; `core_clrn` = 1.
- **ERROR**
  - `rx_ready` = 1; `load_err` = 1.
  - Byte == MAGIC → COUNT and clear `load_err`; other bytes are discarded.
- `rx_ready` is 1 in every state except DONE.
- `load_busy` = 1 in COUNT, DATA and CSUM.
- RAM words beyond index N−1 keep their previous contents.
- A MAGIC byte inside DATA or CSUM is treated as data or checksum; there is no resynchronisation mid-frame.

## Timing
- Reset (`clrn` low at an edge):
  - state = IDLE; counters, sum and word index = 0.
  - Outputs: `rx_ready` = 1, `load_busy` = 0, `load_done` = 0, `load_err` = 0, `core_clrn` = 0.
  - RAM contents are not cleared.
- One byte is consumed per accepted edge. Gaps in `rx_valid` stall the frame indefinitely with no timeout.
- A word written at edge k is visible on `inst` for its address after edge k (zero read latency, combinational).
- `load_done` and `core_clrn` rise on the edge that accepts a valid checksum byte. They are registered outputs decoded from state, not driven by combinational logic from `rx_data`.
- Minimum frame length is 4N+3 accepted bytes, i.e. 4N+3 cycles at full rate.
- Reset during a frame aborts it: the state returns to IDLE and partial words are discarded, but RAM words already written remain.

## Structure
- Package `instmem_pkg`:
  - state enum (6 states);
  - `MAGIC`;
  - `IMEM_DEPTH_LOG2` = 6;
  - `IMEM_WORDS` = 64.
- Sub-module `instmem_ram64`: 64×32, one synchronous write port (`we`, `wa[5:0]`, `wd[31:0]`) and one asynchronous read port (`ra[5:0]` → `rd[31:0]`).
- The top level holds the FSM, byte assembler, checksum and status registers.

## Test plan
- **Nominal load.** Send A5 02 93 04 40 00 57 44 00 01 8D at full rate.
  - After the last edge: `load_done` = 1, `core_clrn` = 1, `rx_ready` = 0.
  - `a` = 0 → `inst` = 32'h00400493; `a` = 4 → `inst` = 32'h01004457.
- **Bad checksum.** Same frame with last byte 8E.
  - `load_err` = 1, `load_done` = 0, `core_clrn` = 0; both words are still readable.
  - Then resend the correct frame → `load_done` = 1, `load_err` = 0.
- **Bad count.** A5 00 → `load_err` = 1. A5 41 → `load_err` = 1. Neither writes any RAM word.
- **Idle noise and stalls.** Send 00 FF 13 before the nominal frame, with `rx_valid` low for 3 cycles between every byte.
  - Noise bytes are ignored; the result is identical to the nominal load.
  - `load_busy` is high from the edge after A5 until the checksum edge.
- **Reset mid-frame.** Drop `clrn` after the 6th byte of the nominal frame.
  - All outputs return to reset values.
  - A full reload then succeeds.
- **Max size.** N = 64 with word i = 32'h1000_0000 + i, correct checksum.
  - `a` = 32'hFC → `inst` = 32'h1000003F.
  - `load_done` = 1 exactly 259 accepted bytes after the frame starts.
